mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer for the MIPS core. It shares one unified instruction/data memory between the fetch stage (instruction read) and the memory stage (`MemRead`/`MemWrite` from the main decoder). It serves pending requests in a fixed order, data first, then instruction. It holds a global pipeline `stall` until every request outstanding in the current cycle is complete, then releases both stages together with a single ready pulse.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle shared by the arbiter, the fetch/MEM pipeline stages and the unified memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_read;
  logic          dm_write;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serves the data access first, then the instruction fetch,
// holding a global stall until everything outstanding is done, then releases both stages at once.
module mem_arbiter #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  typedef enum logic [1:0] {IDLE, ACC_D, ACC_I, DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          we;
  logic          served_d;
  logic          served_i;
  logic          mem_en_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] dm_rdata_r;
  logic          dreq;
  logic          any;

  assign dreq = bus.dm_read | bus.dm_write;
  assign any  = dreq | bus.if_req;

  // DONE is the single cycle in which the pipeline advances, so stall drops there.
  assign bus.stall     = any & (state != DONE);
  assign bus.dm_ready  = (state == DONE) & served_d;
  assign bus.if_ready  = (state == DONE) & served_i;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_rdata  = dm_rdata_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we          <= 1'b0;
      served_d    <= 1'b0;
      served_i    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      dm_rdata_r  <= '0;
    end else begin
      // The memory strobe and its qualifiers exist only in the first cycle of an access.
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      unique case (state)
        IDLE: begin
          if (dreq) begin
            state       <= ACC_D;
            cnt         <= LAT_CNT;
            we          <= bus.dm_write;
            mem_en_r    <= 1'b1;
            mem_we_r    <= bus.dm_write;
            mem_addr_r  <= bus.dm_addr;
            mem_wdata_r <= bus.dm_wdata;
          end else if (bus.if_req) begin
            state      <= ACC_I;
            cnt        <= LAT_CNT;
            we         <= 1'b0;
            mem_en_r   <= 1'b1;
            mem_addr_r <= bus.if_addr;
          end
        end
        ACC_D: begin
          if (cnt == 4'd0) begin
            if (!we) dm_rdata_r <= bus.mem_rdata;
            served_d <= 1'b1;
            if (bus.if_req) begin
              state      <= ACC_I;
              cnt        <= LAT_CNT;
              we         <= 1'b0;
              mem_en_r   <= 1'b1;
              mem_addr_r <= bus.if_addr;
            end else begin
              state <= DONE;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACC_I: begin
          if (cnt == 4'd0) begin
            if_rdata_r <= bus.mem_rdata;
            served_i   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          served_d <= 1'b0;
          served_i <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected strobes, ready pulses and
// stall levels into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

  localparam int LAT = 2;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   t0;
  logic prev_en = 1'b0;

  exp_t strobe_q[$];
  exp_t dm_q[$];
  exp_t if_q[$];
  exp_t stall_q[$];
  rsp_t rsp_q[$];
  logic [31:0] memory [logic [31:0]];

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(.LAT(LAT), .AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifr, input logic [31:0] ifa, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.if_req   = ifr;
    bus.if_addr  = ifa;
    bus.dm_read  = dr;
    bus.dm_write = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expectStrobe(input int c, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.we = w; e.addr = a; e.data = d;
    strobe_q.push_back(e);
  endtask

  task automatic expectDm(input int c, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.we = 1'b0; e.addr = '0; e.data = d;
    dm_q.push_back(e);
  endtask

  task automatic expectIf(input int c, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.we = 1'b0; e.addr = '0; e.data = d;
    if_q.push_back(e);
  endtask

  task automatic expectStall(input int c0, input int c1, input logic v);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.we = v; e.addr = '0; e.data = '0;
      stall_q.push_back(e);
    end
  endtask

  task automatic checkDrained(input string name);
    int left;
    left = strobe_q.size() + dm_q.size() + if_q.size() + stall_q.size();
    checkOutput({name, " pending"}, 32'(left), 32'd0);
    strobe_q.delete();
    dm_q.delete();
    if_q.delete();
    stall_q.delete();
  endtask

  // Memory model: answers each strobe exactly LAT cycles later, garbage otherwise.
  always @(negedge clk) begin
    rsp_t r;
    if (bus.mem_en === 1'b1) begin
      r.due  = cyc + LAT;
      r.data = bus.mem_we ? 32'h5555_AAAA :
               (memory.exists(bus.mem_addr) ? memory[bus.mem_addr] : 32'hBAD0_BAD0);
      rsp_q.push_back(r);
    end
  end

  always @(posedge clk) begin
    #1;
    while (rsp_q.size() > 0 && rsp_q[0].due < cyc) void'(rsp_q.pop_front());
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) bus.mem_rdata = rsp_q.pop_front().data;
    else bus.mem_rdata = 32'hBAD0_BAD0;
  end

  // Monitor: compares every strobe, ready pulse and scheduled stall level with the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (bus.mem_en === 1'b1) begin
        checkOutput("strobe gap", {31'b0, prev_en}, 32'd0);
        if (strobe_q.size() == 0) begin
          checkOutput("unexpected strobe", 32'd1, 32'd0);
        end else begin
          e = strobe_q.pop_front();
          checkOutput("strobe cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("strobe we", {31'b0, bus.mem_we}, {31'b0, e.we});
          checkOutput("strobe addr", bus.mem_addr, e.addr);
          if (e.we) checkOutput("strobe wdata", bus.mem_wdata, e.data);
        end
      end
      if (bus.dm_ready === 1'b1) begin
        if (dm_q.size() == 0) begin
          checkOutput("unexpected dm_ready", 32'd1, 32'd0);
        end else begin
          e = dm_q.pop_front();
          checkOutput("dm_ready cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("dm_rdata", bus.dm_rdata, e.data);
        end
      end
      if (bus.if_ready === 1'b1) begin
        if (if_q.size() == 0) begin
          checkOutput("unexpected if_ready", 32'd1, 32'd0);
        end else begin
          e = if_q.pop_front();
          checkOutput("if_ready cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("if_rdata", bus.if_rdata, e.data);
        end
      end
      while (stall_q.size() > 0 && stall_q[0].cyc <= cyc) begin
        e = stall_q.pop_front();
        checkOutput($sformatf("stall c%0d", e.cyc - t0), {31'b0, bus.stall}, {31'b0, e.we});
      end
    end
    prev_en = bus.mem_en;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    memory[32'h0040_0000] = 32'h2008_0005;
    memory[32'h0040_0004] = 32'h0128_5020;
    memory[32'h0040_0008] = 32'h0800_0010;
    memory[32'h0040_000C] = 32'h2402_0001;
    memory[32'h1000_0004] = 32'h8C09_0010;
    memory[32'h1000_0008] = 32'h1111_2222;
    memory[32'h1000_000C] = 32'h0BAD_F00D;
    bus.mem_rdata = 32'hBAD0_BAD0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(1);

    checkOutput("reset mem_en", {31'b0, bus.mem_en}, 32'd0);
    checkOutput("reset if_ready", {31'b0, bus.if_ready}, 32'd0);
    checkOutput("reset dm_ready", {31'b0, bus.dm_ready}, 32'd0);
    checkOutput("reset dm_rdata", bus.dm_rdata, 32'd0);
    checkOutput("reset if_rdata", bus.if_rdata, 32'd0);
    checkOutput("idle stall", {31'b0, bus.stall}, 32'd0);

    // Instruction fetch only: strobe c1, ready c4.
    t0 = cyc;
    applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    expectStrobe(t0 + 1, 1'b0, 32'h0040_0000, 32'h0);
    expectIf(t0 + 4, 32'h2008_0005);
    expectStall(t0, t0 + 3, 1'b1);
    expectStall(t0 + 4, t0 + 4, 1'b0);
    waitCycles(5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    expectStall(t0 + 5, t0 + 5, 1'b0);
    waitCycles(2);
    checkDrained("fetch");

    // Load plus fetch bundle: strobes c1 and c4, both readies c7.
    t0 = cyc;
    applyStimulus(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
    expectStrobe(t0 + 1, 1'b0, 32'h1000_0004, 32'h0);
    expectStrobe(t0 + 4, 1'b0, 32'h0040_0004, 32'h0);
    expectDm(t0 + 7, 32'h8C09_0010);
    expectIf(t0 + 7, 32'h0128_5020);
    expectStall(t0, t0 + 6, 1'b1);
    expectStall(t0 + 7, t0 + 7, 1'b0);
    waitCycles(8);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycles(2);
    checkDrained("bundle");

    // Store: dm_rdata keeps the previous load value.
    t0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF);
    expectStrobe(t0 + 1, 1'b1, 32'h1000_0008, 32'hDEAD_BEEF);
    expectDm(t0 + 4, 32'h8C09_0010);
    expectStall(t0, t0 + 3, 1'b1);
    expectStall(t0 + 4, t0 + 4, 1'b0);
    waitCycles(5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycles(2);
    checkDrained("store");

    // Read and write together behave as a write.
    t0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_000C, 32'h1234_5678);
    expectStrobe(t0 + 1, 1'b1, 32'h1000_000C, 32'h1234_5678);
    expectDm(t0 + 4, 32'h8C09_0010);
    waitCycles(5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycles(2);
    checkDrained("read+write");

    // Fetch held across DONE: next strobe two cycles after DONE.
    t0 = cyc;
    applyStimulus(1'b1, 32'h0040_0008, 1'b0, 1'b0, 32'h0, 32'h0);
    expectStrobe(t0 + 1, 1'b0, 32'h0040_0008, 32'h0);
    expectIf(t0 + 4, 32'h0800_0010);
    expectStall(t0 + 4, t0 + 4, 1'b0);
    expectStall(t0 + 5, t0 + 8, 1'b1);
    expectStrobe(t0 + 6, 1'b0, 32'h0040_0008, 32'h0);
    expectIf(t0 + 9, 32'h0800_0010);
    expectStall(t0 + 9, t0 + 9, 1'b0);
    waitCycles(10);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycles(2);
    checkDrained("held");

    // Reset in cycle 2 of a load aborts it; a fetch in cycle 3 is served normally.
    t0 = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
    expectStrobe(t0 + 1, 1'b0, 32'h1000_0004, 32'h0);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h0040_000C, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("post-reset mem_en", {31'b0, bus.mem_en}, 32'd0);
    checkOutput("post-reset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("post-reset dm_ready", {31'b0, bus.dm_ready}, 32'd0);
    checkOutput("post-reset dm_rdata", bus.dm_rdata, 32'd0);
    checkOutput("post-reset if_rdata", bus.if_rdata, 32'd0);
    checkOutput("post-reset stall", {31'b0, bus.stall}, 32'd1);
    expectStrobe(t0 + 4, 1'b0, 32'h0040_000C, 32'h0);
    expectIf(t0 + 7, 32'h2402_0001);
    expectStall(t0 + 7, t0 + 7, 1'b0);
    waitCycles(5);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitCycles(2);
    checkDrained("reset abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
